// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the hazard/decode logic in ID and the stall sequencer.
// master: the ID-stage side that raises hazard, MULT/DIV and branch/jump requests
//         and consumes the pipeline enables.
// slave : the stall sequencer itself.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             load_use_hz;
  logic             branch_hz;
  logic             md_start;
  logic             branch_taken;
  logic             jump;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             bubble_sel;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output load_use_hz,
    output branch_hz,
    output md_start,
    output branch_taken,
    output jump,
    input  pc_write,
    input  ifid_write,
    input  ifid_flush,
    input  bubble_sel,
    input  md_busy,
    input  stall_cnt,
    input  flush_cnt
  );

  modport slave (
    input  load_use_hz,
    input  branch_hz,
    input  md_start,
    input  branch_taken,
    input  jump,
    output pc_write,
    output ifid_write,
    output ifid_flush,
    output bubble_sel,
    output md_busy,
    output stall_cnt,
    output flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer for the 5-stage MIPS core, placed beside ID.
// Merges load-use / branch-operand hazards, a MULT/DIV occupancy FSM and
// taken-branch/jump flush requests into PC / IF/ID / ID/EX control.
// Optional macro PIPE_PERF_CNT_EN: when defined, saturating stall/flush
// performance counters are built; otherwise both counter outputs are tied to 0.
module pipeline_stall_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);

  // Counter reload value: the FSM spends md_cnt+1 cycles in MD_BUSY.
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] md_cnt;
  logic [7:0] md_cnt_nxt;

  logic       hazard;
  logic       redirect;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       bubble_sel;
  logic       md_busy;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Any operand hazard stalls the instruction in ID, re-evaluated every cycle.
  assign hazard   = bus.load_use_hz | bus.branch_hz;
  assign redirect = bus.branch_taken | bus.jump;

  // State register and MULT/DIV occupancy counter; reset aborts any busy period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state logic: hazards block a MULT/DIV issue; busy ignores all requests.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      RUN: begin
        if (!hazard && bus.md_start) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt == 8'd0) begin
          state_nxt = RUN;
        end else begin
          md_cnt_nxt = md_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: default is a full hold with a bubble, which is also the reset view.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    bubble_sel = 1'b1;
    md_busy    = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (hazard) begin
            // hold PC and IF/ID, inject a bubble into ID/EX
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
          end else if (bus.md_start) begin
            // the MULT/DIV op itself moves into ID/EX; fetch is frozen behind it
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b0;
          end else if (redirect) begin
            // redirect target is fetched; the wrong-path fetch is squashed
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            bubble_sel = 1'b0;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            bubble_sel = 1'b0;
          end
        end
        MD_BUSY: begin
          // instruction in ID is frozen and re-decoded once the unit frees up
          md_busy = 1'b1;
        end
        default: begin
          md_busy = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Performance counters: stalled-fetch cycles and IF/ID flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (ifid_flush) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.bubble_sel = bubble_sel;
  assign bus.md_busy    = md_busy;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MD_CYCLES=4 and CNT_W=4.
module tb_pipeline_stall_ctrl;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 4;

  logic clk;
  logic rst;

  int n_checks;
  int n_fails;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

  pipeline_stall_ctrl #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value: real count when counters are built, 0 otherwise.
  function automatic int ex(input int n);
`ifdef PIPE_PERF_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic lu, input logic bh, input logic ms,
                       input logic bt, input logic jp);
    bus_if.load_use_hz  = lu;
    bus_if.branch_hz    = bh;
    bus_if.md_start     = ms;
    bus_if.branch_taken = bt;
    bus_if.jump         = jp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset with every request high
    rst = 1'b1;
    drive(1, 1, 1, 1, 1);
    #2;
    check("rst_pc_write",   int'(bus_if.pc_write),   0);
    check("rst_ifid_write", int'(bus_if.ifid_write), 0);
    check("rst_bubble_sel", int'(bus_if.bubble_sel), 1);
    check("rst_md_busy",    int'(bus_if.md_busy),    0);
    check("rst_ifid_flush", int'(bus_if.ifid_flush), 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_stall_cnt",  int'(bus_if.stall_cnt),  0);
    check("rst_flush_cnt",  int'(bus_if.flush_cnt),  0);
    check("rst_md_busy_clk", int'(bus_if.md_busy),   0);
    next_cycle();

    // Release with idle inputs: normal flow
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("run_pc_write",   int'(bus_if.pc_write),   1);
    check("run_ifid_write", int'(bus_if.ifid_write), 1);
    check("run_bubble_sel", int'(bus_if.bubble_sel), 0);
    check("run_ifid_flush", int'(bus_if.ifid_flush), 0);
    next_cycle();

    // One-cycle load-use stall
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("lu_pc_write",   int'(bus_if.pc_write),   0);
    check("lu_ifid_write", int'(bus_if.ifid_write), 0);
    check("lu_bubble_sel", int'(bus_if.bubble_sel), 1);
    check("lu_stall_cnt0", int'(bus_if.stall_cnt),  0);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("lu_release_pc_write", int'(bus_if.pc_write),   1);
    check("lu_release_bubble",   int'(bus_if.bubble_sel), 0);
    check("lu_stall_cnt1",       int'(bus_if.stall_cnt),  ex(1));
    next_cycle();

    // Branch hazard together with taken branch: stall wins, no flush
    drive(0, 1, 0, 1, 0);
    @(negedge clk);
    check("bh_bt_pc_write",   int'(bus_if.pc_write),   0);
    check("bh_bt_ifid_flush", int'(bus_if.ifid_flush), 0);
    check("bh_bt_bubble_sel", int'(bus_if.bubble_sel), 1);
    next_cycle();
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    check("bt_ifid_flush", int'(bus_if.ifid_flush), 1);
    check("bt_pc_write",   int'(bus_if.pc_write),   1);
    check("bt_ifid_write", int'(bus_if.ifid_write), 1);
    check("bt_bubble_sel", int'(bus_if.bubble_sel), 0);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("bt_flush_cnt", int'(bus_if.flush_cnt),  ex(1));
    check("bt_stall_cnt", int'(bus_if.stall_cnt),  ex(2));
    check("bt_no_flush",  int'(bus_if.ifid_flush), 0);
    next_cycle();

    // Load-use with md_start: hazard wins, MULT/DIV does not start
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check("lu_md_bubble_sel", int'(bus_if.bubble_sel), 1);
    check("lu_md_pc_write",   int'(bus_if.pc_write),   0);
    next_cycle();

    // MULT/DIV issue
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    check("md_issue_busy",       int'(bus_if.md_busy),    0);
    check("md_issue_bubble_sel", int'(bus_if.bubble_sel), 0);
    check("md_issue_pc_write",   int'(bus_if.pc_write),   0);
    check("md_issue_ifid_write", int'(bus_if.ifid_write), 0);
    next_cycle();

    // Busy for exactly 4 cycles; branch/jump/md_start are ignored
    drive(0, 0, 1, 1, 1);
    for (int i = 0; i < MD_CYCLES; i++) begin
      @(negedge clk);
      check($sformatf("md_busy_%0d", i),  int'(bus_if.md_busy),    1);
      check($sformatf("md_pc_%0d", i),    int'(bus_if.pc_write),   0);
      check($sformatf("md_flush_%0d", i), int'(bus_if.ifid_flush), 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("md_done_busy",      int'(bus_if.md_busy),   0);
    check("md_done_pc_write",  int'(bus_if.pc_write),  1);
    check("md_done_stall_cnt", int'(bus_if.stall_cnt), ex(8));
    next_cycle();

    // Jump flush
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    check("jmp_ifid_flush", int'(bus_if.ifid_flush), 1);
    check("jmp_pc_write",   int'(bus_if.pc_write),   1);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("jmp_flush_cnt", int'(bus_if.flush_cnt), ex(2));
    next_cycle();

    // Abort on the second busy cycle
    drive(0, 0, 1, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("abort_busy1", int'(bus_if.md_busy), 1);
    next_cycle();
    @(negedge clk);
    check("abort_busy2", int'(bus_if.md_busy), 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_md_busy",    int'(bus_if.md_busy),    0);
    check("abort_pc_write",   int'(bus_if.pc_write),   0);
    check("abort_bubble_sel", int'(bus_if.bubble_sel), 1);
    check("abort_stall_cnt",  int'(bus_if.stall_cnt),  0);
    check("abort_flush_cnt",  int'(bus_if.flush_cnt),  0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_abort_busy",     int'(bus_if.md_busy),   0);
    check("post_abort_pc_write", int'(bus_if.pc_write),  1);
    check("post_abort_stall",    int'(bus_if.stall_cnt), 0);
    next_cycle();

    // Fresh MULT/DIV gets full occupancy
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    check("md2_issue_bubble", int'(bus_if.bubble_sel), 0);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < MD_CYCLES; i++) begin
      @(negedge clk);
      check($sformatf("md2_busy_%0d", i), int'(bus_if.md_busy), 1);
      next_cycle();
    end
    @(negedge clk);
    check("md2_done_busy",  int'(bus_if.md_busy),   0);
    check("md2_stall_cnt",  int'(bus_if.stall_cnt), ex(5));
    next_cycle();

    // Saturation: 5 + 20 stalled cycles clamp at 15
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) begin
        check("sat_stall_cnt_mid", int'(bus_if.stall_cnt), ex(15));
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_stall_cnt_end", int'(bus_if.stall_cnt), ex(15));
    check("sat_flush_cnt",     int'(bus_if.flush_cnt), 0);
    check("sat_pc_write",      int'(bus_if.pc_write),  1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
